// File: rtl/pwm_multi_ch.sv
// N-channel PWM engine: one shared prescaled up/down/center counter feeding per-channel
// compare logic, with double-buffered period/compare/function values behind a byte register bus.
module pwm_multi_ch #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int PRESC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [5:0]        addr,
   input  logic [7:0]        data_write,
   output logic [7:0]        data_read,
   output logic [CNT_W-1:0]  counter_val,
   output logic              period_tick,
   output logic [NUM_CH-1:0] pwm_out
);

   logic [CNT_W-1:0]   period_stg_q, period_stg_d, period_act_q, period_act_d;
   logic               en_q, en_d, up_q, up_d, center_q, center_d;
   logic [PRESC_W-1:0] presc_val_q, presc_val_d, presc_cnt_q, presc_cnt_d;
   logic [NUM_CH-1:0]  pwm_en_q, pwm_en_d, pwm_q, pwm_d;
   logic [CNT_W-1:0]   cmp1_stg_q [NUM_CH];
   logic [CNT_W-1:0]   cmp1_stg_d [NUM_CH];
   logic [CNT_W-1:0]   cmp2_stg_q [NUM_CH];
   logic [CNT_W-1:0]   cmp2_stg_d [NUM_CH];
   logic [CNT_W-1:0]   cmp1_act_q [NUM_CH];
   logic [CNT_W-1:0]   cmp1_act_d [NUM_CH];
   logic [CNT_W-1:0]   cmp2_act_q [NUM_CH];
   logic [CNT_W-1:0]   cmp2_act_d [NUM_CH];
   logic [7:0]         func_stg_q [NUM_CH];
   logic [7:0]         func_stg_d [NUM_CH];
   logic [2:0]         func_act_q [NUM_CH];
   logic [2:0]         func_act_d [NUM_CH];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_dn_q, dir_dn_d, ptick_q, ptick_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               tick, pb, load, count_rst, raw;

   // Registers narrower than 16 bits are viewed as a zero-extended L/H byte pair.
   function automatic logic [CNT_W-1:0] wr_byte(input logic [CNT_W-1:0] cur, input logic hi,
                                                input logic [7:0] b);
      logic [15:0] ext;
      ext = 16'(cur);
      if (hi) ext[15:8] = b;
      else    ext[7:0]  = b;
      return ext[CNT_W-1:0];
   endfunction

   function automatic logic [7:0] rd_byte(input logic [CNT_W-1:0] cur, input logic hi);
      logic [15:0] ext;
      ext = 16'(cur);
      return hi ? ext[15:8] : ext[7:0];
   endfunction

   always_comb begin
      period_stg_d = period_stg_q;
      en_d         = en_q;
      up_d         = up_q;
      center_d     = center_q;
      presc_val_d  = presc_val_q;
      pwm_en_d     = pwm_en_q;
      cmp1_stg_d   = cmp1_stg_q;
      cmp2_stg_d   = cmp2_stg_q;
      func_stg_d   = func_stg_q;
      count_rst    = 1'b0;
      rdata_d      = rdata_q;
      if (write) begin
         case (addr)
            6'h00: period_stg_d = wr_byte(period_stg_q, 1'b0, data_write);
            6'h01: period_stg_d = wr_byte(period_stg_q, 1'b1, data_write);
            6'h02: begin
               en_d      = data_write[0];
               up_d      = data_write[1];
               center_d  = data_write[2];
               count_rst = data_write[3];
            end
            6'h03: presc_val_d = data_write[PRESC_W-1:0];
            6'h04: pwm_en_d    = data_write[NUM_CH-1:0];
            default: ;
         endcase
         for (int n = 0; n < NUM_CH; n++) begin
            if (addr == 6'(8 + 6*n))  cmp1_stg_d[n] = wr_byte(cmp1_stg_q[n], 1'b0, data_write);
            if (addr == 6'(9 + 6*n))  cmp1_stg_d[n] = wr_byte(cmp1_stg_q[n], 1'b1, data_write);
            if (addr == 6'(10 + 6*n)) cmp2_stg_d[n] = wr_byte(cmp2_stg_q[n], 1'b0, data_write);
            if (addr == 6'(11 + 6*n)) cmp2_stg_d[n] = wr_byte(cmp2_stg_q[n], 1'b1, data_write);
            if (addr == 6'(12 + 6*n)) func_stg_d[n] = data_write;
         end
      end
      if (read) begin
         rdata_d = 8'h00;
         case (addr)
            6'h00: rdata_d = rd_byte(period_stg_q, 1'b0);
            6'h01: rdata_d = rd_byte(period_stg_q, 1'b1);
            6'h02: rdata_d = {5'b0, center_q, up_q, en_q};
            6'h03: rdata_d = 8'(presc_val_q);
            6'h04: rdata_d = 8'(pwm_en_q);
            6'h05: rdata_d = rd_byte(cnt_q, 1'b0);
            6'h06: rdata_d = rd_byte(cnt_q, 1'b1);
            default: ;
         endcase
         for (int n = 0; n < NUM_CH; n++) begin
            if (addr == 6'(8 + 6*n))  rdata_d = rd_byte(cmp1_stg_q[n], 1'b0);
            if (addr == 6'(9 + 6*n))  rdata_d = rd_byte(cmp1_stg_q[n], 1'b1);
            if (addr == 6'(10 + 6*n)) rdata_d = rd_byte(cmp2_stg_q[n], 1'b0);
            if (addr == 6'(11 + 6*n)) rdata_d = rd_byte(cmp2_stg_q[n], 1'b1);
            if (addr == 6'(12 + 6*n)) rdata_d = func_stg_q[n];
         end
      end
   end

   always_comb begin
      presc_cnt_d = presc_cnt_q;
      cnt_d       = cnt_q;
      dir_dn_d    = dir_dn_q;
      pb          = 1'b0;
      tick        = en_q && (presc_cnt_q >= presc_val_q);
      if (en_q) presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) begin
         if (center_q) begin
            if (!dir_dn_q && (cnt_q < period_act_q)) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Turn around at the top; reaching 0 closes the period and restarts upward.
               cnt_d    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
               pb       = (cnt_d == '0);
               dir_dn_d = !pb;
            end
         end else if (up_q) begin
            if (cnt_q >= period_act_q) begin
               cnt_d = '0;
               pb    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (cnt_q == '0) begin
               cnt_d = period_act_q;
               pb    = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end
      load = pb || !en_q;
      if (count_rst) begin
         presc_cnt_d = '0;
         cnt_d       = '0;
         dir_dn_d    = 1'b0;
         pb          = 1'b0;
         load        = 1'b1;
      end
      ptick_d      = pb;
      period_act_d = load ? period_stg_q : period_act_q;
      for (int n = 0; n < NUM_CH; n++) begin
         cmp1_act_d[n] = load ? cmp1_stg_q[n] : cmp1_act_q[n];
         cmp2_act_d[n] = load ? cmp2_stg_q[n] : cmp2_act_q[n];
         func_act_d[n] = load ? func_stg_q[n][2:0] : func_act_q[n];
      end
   end

   always_comb begin
      pwm_d = '0;
      raw   = 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
         case (func_act_q[n][1:0])
            2'b00:   raw = cnt_q < cmp1_act_q[n];
            2'b01:   raw = cnt_q >= cmp1_act_q[n];
            2'b10:   raw = (cnt_q >= cmp1_act_q[n]) && (cnt_q < cmp2_act_q[n]);
            default: raw = 1'b0;
         endcase
         pwm_d[n] = pwm_en_q[n] & (raw ^ func_act_q[n][2]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_stg_q <= '0;
         period_act_q <= '0;
         en_q         <= 1'b0;
         up_q         <= 1'b0;
         center_q     <= 1'b0;
         presc_val_q  <= '0;
         presc_cnt_q  <= '0;
         pwm_en_q     <= '0;
         pwm_q        <= '0;
         cnt_q        <= '0;
         dir_dn_q     <= 1'b0;
         ptick_q      <= 1'b0;
         rdata_q      <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            cmp1_stg_q[n] <= '0;
            cmp2_stg_q[n] <= '0;
            cmp1_act_q[n] <= '0;
            cmp2_act_q[n] <= '0;
            func_stg_q[n] <= '0;
            func_act_q[n] <= '0;
         end
      end else begin
         period_stg_q <= period_stg_d;
         period_act_q <= period_act_d;
         en_q         <= en_d;
         up_q         <= up_d;
         center_q     <= center_d;
         presc_val_q  <= presc_val_d;
         presc_cnt_q  <= presc_cnt_d;
         pwm_en_q     <= pwm_en_d;
         pwm_q        <= pwm_d;
         cnt_q        <= cnt_d;
         dir_dn_q     <= dir_dn_d;
         ptick_q      <= ptick_d;
         rdata_q      <= rdata_d;
         cmp1_stg_q   <= cmp1_stg_d;
         cmp2_stg_q   <= cmp2_stg_d;
         cmp1_act_q   <= cmp1_act_d;
         cmp2_act_q   <= cmp2_act_d;
         func_stg_q   <= func_stg_d;
         func_act_q   <= func_act_d;
      end
   end

   assign data_read   = rdata_q;
   assign counter_val = cnt_q;
   assign period_tick = ptick_q;
   assign pwm_out     = pwm_q;

endmodule
